// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared widths, limits and result type for the fpcvt integer-to-float converter
package fpcvt_pkg;

    localparam int D_W = 13;
    localparam int E_W = 3;
    localparam int F_W = 5;
    localparam int M_W = 12;

    localparam logic [E_W-1:0] E_MAX = 3'd7;
    localparam logic [F_W-1:0] F_MAX = 5'd31;

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } fpcvt_res_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// rtl/fpcvt_lzc.sv - combinational 12-bit leading-zero counter for fpcvt
module fpcvt_lzc
    import fpcvt_pkg::*;
(
    input  logic [M_W-1:0] m,
    output logic [3:0]     lz
);

    // Scan from LSB upward so the highest set bit is the last one to win.
    always_comb begin
        lz = 4'd12;
        for (int i = 0; i < M_W; i++) begin
            if (m[i]) begin
                lz = 4'(M_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpcvt.sv
// rtl/fpcvt.sv - registered 13-bit integer to {S,E[2:0],F[4:0]} float converter; FPCVT_SAT_FLAG_EN adds a sat output
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [D_W-1:0] D,
    input  logic           in_valid,
    output logic           S,
    output logic [E_W-1:0] E,
    output logic [F_W-1:0] F,
`ifdef FPCVT_SAT_FLAG_EN
    output logic           sat,
`endif
    output logic           out_valid
);

    logic [D_W-1:0] neg_d;
    logic           d_min;
    logic [M_W-1:0] mag;
    logic [3:0]     lz;
    logic [6:0]     top7;
    logic [F_W:0]   f_sum;
    logic           sat_now;
    fpcvt_res_t     conv;

    fpcvt_res_t     res_d, res_q;
    logic           out_valid_d, out_valid_q;
    logic           sat_d, sat_q;

    fpcvt_lzc u_lzc (
        .m  (mag),
        .lz (lz)
    );

    always_comb begin
        neg_d   = D_W'(~D + 1'b1);
        d_min   = (D == 13'h1000);
        mag     = '0;
        top7    = '0;
        f_sum   = '0;
        sat_now = 1'b0;
        conv    = '0;

        conv.s = D[D_W-1];
        if (d_min) begin
            mag = '1;
        end else if (D[D_W-1]) begin
            mag = neg_d[M_W-1:0];
        end else begin
            mag = D[M_W-1:0];
        end

        if (lz >= 4'd7) begin
            conv.e = '0;
            conv.f = mag[F_W-1:0];
        end else begin
            // Left-justify the magnitude: top5 is the significand, the next bit rounds.
            top7   = 7'((mag << lz) >> 5);
            conv.e = 3'(4'd7 - lz);
            f_sum  = {1'b0, top7[6:2]} + {5'd0, top7[1]};
            if (f_sum[F_W]) begin
                if (conv.e == E_MAX) begin
                    conv.f  = F_MAX;
                    sat_now = 1'b1;
                end else begin
                    conv.e = conv.e + 3'd1;
                    conv.f = 5'd16;
                end
            end else begin
                conv.f = f_sum[F_W-1:0];
            end
        end
        sat_now = sat_now | d_min;
    end

    always_comb begin
        res_d       = res_q;
        sat_d       = sat_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            res_d = conv;
            sat_d = sat_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S         = res_q.s;
    assign E         = res_q.e;
    assign F         = res_q.f;
    assign out_valid = out_valid_q;
`ifdef FPCVT_SAT_FLAG_EN
    assign sat       = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_fpcvt.sv
// tb/tb_fpcvt.sv - table-driven and scoreboard bench for fpcvt; honours FPCVT_SAT_FLAG_EN
module tb_fpcvt;

    typedef struct {
        int d;
        bit s;
        int e;
        int f;
        bit sat;
    } vec_t;

    typedef struct {
        logic       s;
        logic [2:0] e;
        logic [4:0] f;
        logic       sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] D;
    logic        in_valid;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;
    logic        out_valid;
`ifdef FPCVT_SAT_FLAG_EN
    logic        sat;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    exp_t last_exp;
    vec_t tbl[$];

    fpcvt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .in_valid  (in_valid),
        .S         (S),
        .E         (E),
        .F         (F),
`ifdef FPCVT_SAT_FLAG_EN
        .sat       (sat),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: round |d| / 2^e to nearest (half up) with the smallest e keeping F under 32.
    function automatic exp_t model(input logic [12:0] d);
        exp_t r;
        int   v, m, p, e, f;
        v     = int'($signed(d));
        r.s   = d[12];
        r.sat = 1'b0;
        m     = (v < 0) ? -v : v;
        if (m > 4095) begin
            m     = 4095;
            r.sat = 1'b1;
        end
        if (m < 32) begin
            e = 0;
            f = m;
        end else begin
            p = 0;
            for (int i = 0; i < 12; i++) if ((m >> i) & 1) p = i;
            e = p - 4;
            f = (m + (1 << (e - 1))) >> e;
            if (f == 32) begin
                f = 16;
                e = e + 1;
            end
            if (e > 7) begin
                e     = 7;
                f     = 31;
                r.sat = 1'b1;
            end
        end
        r.e = 3'(e);
        r.f = 5'(f);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at %0t", $time);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("S", int'(S), int'(x.s));
                chk("E", int'(E), int'(x.e));
                chk("F", int'(F), int'(x.f));
`ifdef FPCVT_SAT_FLAG_EN
                chk("sat", int'(sat), int'(x.sat));
`endif
                last_exp = x;
            end
        end
    end

    task automatic drive(input logic [12:0] d, input exp_t x);
        @(posedge clk);
        #1;
        D        = d;
        in_valid = 1'b1;
        sbq.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t x;
        logic [12:0] rd;

        tbl.push_back('{0,     0, 0, 0,  0});
        tbl.push_back('{1,     0, 0, 1,  0});
        tbl.push_back('{10,    0, 0, 10, 0});
        tbl.push_back('{20,    0, 0, 20, 0});
        tbl.push_back('{30,    0, 0, 30, 0});
        tbl.push_back('{40,    0, 1, 20, 0});
        tbl.push_back('{15,    0, 0, 15, 0});
        tbl.push_back('{-400,  1, 4, 25, 0});
        tbl.push_back('{50,    0, 1, 25, 0});
        tbl.push_back('{100,   0, 2, 25, 0});
        tbl.push_back('{253,   0, 4, 16, 0});
        tbl.push_back('{4095,  0, 7, 31, 1});
        tbl.push_back('{-4096, 1, 7, 31, 1});
        tbl.push_back('{31,    0, 0, 31, 0});
        tbl.push_back('{32,    0, 1, 16, 0});
        tbl.push_back('{63,    0, 2, 16, 0});
        tbl.push_back('{-1,    1, 0, 1,  0});
        tbl.push_back('{4031,  0, 7, 31, 0});
        tbl.push_back('{4032,  0, 7, 31, 1});

        rst_n    = 1'b0;
        D        = '0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_S", int'(S), 0);
        chk("reset_E", int'(E), 0);
        chk("reset_F", int'(F), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        sbq.push_back('{1'b0, 3'd0, 5'd0, 1'b0});

        foreach (tbl[i]) begin
            x.s   = tbl[i].s;
            x.e   = 3'(tbl[i].e);
            x.f   = 5'(tbl[i].f);
            x.sat = tbl[i].sat;
            drive(13'(tbl[i].d), x);
        end

        for (int i = 0; i < 200; i++) begin
            rd = 13'($urandom);
            drive(rd, model(rd));
        end

        // Idle cycles: results hold, out_valid drops.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        D        = 13'd123;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            D = 13'd456;
            chk("hold_out_valid", int'(out_valid), 0);
            chk("hold_S", int'(S), int'(last_exp.s));
            chk("hold_E", int'(E), int'(last_exp.e));
            chk("hold_F", int'(F), int'(last_exp.f));
        end
        chk("sb_drained", sbq.size(), 0);

        // Reset mid-stream clears outputs without waiting for a clock edge.
        @(posedge clk);
        #1;
        D        = 13'd4095;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_E", int'(E), 7);
        chk("pre_reset_F", int'(F), 31);
        chk("pre_reset_out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_S", int'(S), 0);
        chk("async_reset_E", int'(E), 0);
        chk("async_reset_F", int'(F), 0);
        chk("async_reset_out_valid", int'(out_valid), 0);
`ifdef FPCVT_SAT_FLAG_EN
        chk("async_reset_sat", int'(sat), 0);
`endif
        @(posedge clk);
        #1;
        chk("reset_wins_out_valid", int'(out_valid), 0);
        chk("reset_wins_E", int'(E), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_out_valid", int'(out_valid), 0);
        chk("post_reset_F", int'(F), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpcvt.md
Name: fpcvt

Overview:
- Converts a 13-bit two's-complement integer into an 9-bit floating-point code: sign S, 3-bit exponent E and 5-bit significand F.
- Represented value is (-1)^S × F × 2^E.
- Sits on a datapath as a registered, one-cycle-latency converter with a simple valid pipeline.
- Conversion is purely combinational internally; outputs are registered.

Parameters:
- none. All widths are fixed: D 13 bits, E 3 bits, F 5 bits. The widths are shared as package constants, not overridable parameters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D  in  13  two's-complement input sample
- in_valid  in  1  D is valid this cycle
- S  out  1  sign bit, registered
- E  out  3  exponent, registered
- F  out  5  significand, registered
- out_valid  out  1  S/E/F hold a fresh result

Behaviour:
- Reset: while rst_n=0, S=0, E=0, F=0 and out_valid=0, asynchronously. Release takes effect at the next clk edge.
- Latency: exactly 1 cycle.
  - On each rising clk with in_valid=1: S/E/F <= convert(D) and out_valid <= 1.
  - With in_valid=0: S/E/F hold their values and out_valid <= 0.
- No backpressure. A new sample is accepted every cycle.
- Sign: S = D[12].
- Magnitude M (12 bits):
  - M = D[11:0] if S=0.
  - M = two's-complement negation of D if S=1.
  - D = -4096 (13'h1000) cannot be represented, so M saturates to 4095.
- Normalisation: lz = number of leading zeros of M, counted in 12 bits (0..12).
  - If lz >= 7: E = 0, F = M[4:0], no rounding.
  - Else: E = 7 - lz, F = M[11-lz : 7-lz], round bit R = M[6-lz].
- Rounding: round-half-up on R.
  - If R=1, F = F + 1.
  - If F was 31, F becomes 16 and E increments.
  - If E was already 7, saturate: E=7, F=31 (value 3968).
- Zero input gives S=0, E=0, F=0.
- Simultaneous reset and in_valid: reset wins.
- Reset mid-stream discards the in-flight result.

Optional Feature:
- Macro FPCVT_SAT_FLAG_EN.
- When defined: adds output port sat (1 bit, registered, reset 0, same timing as S/E/F).
  - sat=1 when the result saturated, i.e. D=-4096 or a rounding carry at E=7.
  - sat=0 otherwise.
- When undefined: the port is absent and conversion behaviour is identical.

Decomposition:
- Package fpcvt_pkg holds:
  - constants D_W=13, E_W=3, F_W=5, M_W=12, E_MAX=3'd7, F_MAX=5'd31;
  - typedef of the {S,E,F} result struct.
- One sub-module, fpcvt_lzc: combinational 12-bit leading-zero counter / priority encoder returning lz (4 bits).
- Magnitude, rounding and output registers live in fpcvt.

Test Plan:
- Reset asserted, then D=0 with in_valid=1 -> outputs 0 during reset; one cycle after release S=0,E=0,F=0, out_valid=1.
- Small and exact values, one per cycle: D=1, 10, 20, 30, 40, 15 (each out_valid=1 one cycle later):
  - 1 -> E=0,F=1
  - 10 -> E=0,F=10
  - 20 -> E=0,F=20
  - 30 -> E=0,F=30
  - 40 -> E=1,F=20
  - 15 -> E=0,F=15
- Negative input: D=-400 -> S=1, E=4, F=25.
- Mid-range exact and rounding-carry cases:
  - D=50 -> S=0,E=1,F=25
  - D=100 -> E=2,F=25
  - D=253 -> E=4,F=16 (carry renormalises)
- Saturation cases:
  - D=4095 -> S=0,E=7,F=31
  - D=-4096 -> S=1,E=7,F=31
  - sat=1 for both when FPCVT_SAT_FLAG_EN is defined.
- Handshake: in_valid=0 for 2 cycles with changing D -> S/E/F hold, out_valid=0. Assert rst_n=0 mid-stream -> outputs clear immediately.
